id_ex_stage: RTL and testbench

Pipeline register between the decode stage (register file, immediate generator, `Control`) and the execute stage, with the load-use hazard detector embedded. The block owns the EX-stage copy of `MemRead` and `rd`, so it detects load-use dependencies itself. On a dependency it raises `NoOp_o` into `Control`, holds PC and IF/ID, and latches a bubble. A saturating bubble counter is provided for performance debug.

---
 rtl/id_ex_stage_pkg.sv | 25 ++
 rtl/id_ex_stage_hazard.sv | 23 ++
 rtl/id_ex_stage.sv | 127 ++++++++++++
 tb/tb_id_ex_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX pipeline slice.
//   aluop_e   : ALU operation class produced by Control.
//   ex_ctrl_t : EX-stage control bundle carried through the ID/EX register.
//   EX_CTRL_BUBBLE : all-zero bundle latched when a bubble is inserted.
package id_ex_stage_pkg;

  typedef enum logic [1:0] {
    ALUOP_LOADSTORE = 2'b00,
    ALUOP_BRANCH    = 2'b01,
    ALUOP_RTYPE     = 2'b10,
    ALUOP_ITYPE     = 2'b11
  } aluop_e;

  typedef struct packed {
    logic   regwrite;
    logic   memtoreg;
    logic   memread;
    logic   memwrite;
    aluop_e aluop;
    logic   alusrc;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detector (combinational).
// Ports:
//   i_memread : EX-stage MemRead
//   i_ex_rd   : EX-stage destination register
//   i_id_rs1  : ID-stage rs1 field
//   i_id_rs2  : ID-stage rs2 field
//   o_haz     : load-use dependency present
// Both source fields are compared regardless of format; a false stall on
// I-type instructions is accepted.
module hazard_detect (
  input  logic       i_memread,
  input  logic [4:0] i_ex_rd,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  output logic       o_haz
);

  always_comb begin
    o_haz = i_memread && (i_ex_rd != 5'd0) &&
            ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with embedded load-use hazard detection.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-low reset
//   *_i control / data      : decode-stage values captured each cycle
//   *_o control / data      : EX-stage registered copies
//   NoOp_o, Stall_o         : asserted combinationally on a load-use hazard
//   PCWrite_o               : inverse of Stall_o
//   BubbleCnt_o             : saturating count of inserted bubbles
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             ALUSrc_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [XLEN-1:0]  RS1data_i,
  input  logic [XLEN-1:0]  RS2data_i,
  input  logic [XLEN-1:0]  Imm_i,
  input  logic [9:0]       Funct_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  input  logic [4:0]       RDaddr_i,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             ALUSrc_o,
  output logic [1:0]       ALUOp_o,
  output logic [XLEN-1:0]  RS1data_o,
  output logic [XLEN-1:0]  RS2data_o,
  output logic [XLEN-1:0]  Imm_o,
  output logic [9:0]       Funct_o,
  output logic [4:0]       RS1addr_o,
  output logic [4:0]       RS2addr_o,
  output logic [4:0]       RDaddr_o,
  output logic             NoOp_o,
  output logic             Stall_o,
  output logic             PCWrite_o,
  output logic [CNT_W-1:0] BubbleCnt_o
);

  ex_ctrl_t          r_ctrl;
  ex_ctrl_t          w_ctrl_in;
  logic [XLEN-1:0]   r_rs1data;
  logic [XLEN-1:0]   r_rs2data;
  logic [XLEN-1:0]   r_imm;
  logic [9:0]        r_funct;
  logic [4:0]        r_rs1addr;
  logic [4:0]        r_rs2addr;
  logic [4:0]        r_rdaddr;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic              w_haz;

  // Hazard uses only registered EX state and ID address fields, so the
  // Control outputs (which depend on NoOp_o) never feed back into w_haz.
  hazard_detect u_hazard_detect (
    .i_memread (r_ctrl.memread),
    .i_ex_rd   (r_rdaddr),
    .i_id_rs1  (RS1addr_i),
    .i_id_rs2  (RS2addr_i),
    .o_haz     (w_haz)
  );

  always_comb begin
    w_ctrl_in          = EX_CTRL_BUBBLE;
    w_ctrl_in.regwrite = RegWrite_i;
    w_ctrl_in.memtoreg = MemtoReg_i;
    w_ctrl_in.memread  = MemRead_i;
    w_ctrl_in.memwrite = MemWrite_i;
    w_ctrl_in.aluop    = aluop_e'(ALUOp_i);
    w_ctrl_in.alusrc   = ALUSrc_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ctrl       <= EX_CTRL_BUBBLE;
      r_rs1data    <= '0;
      r_rs2data    <= '0;
      r_imm        <= '0;
      r_funct      <= '0;
      r_rs1addr    <= '0;
      r_rs2addr    <= '0;
      r_rdaddr     <= '0;
      r_bubble_cnt <= '0;
    end else begin
      // Bubble forces control to zero even though Control also sees NoOp_o;
      // data/address fields are don't-care in a bubble and still capture.
      r_ctrl    <= w_haz ? EX_CTRL_BUBBLE : w_ctrl_in;
      r_rs1data <= RS1data_i;
      r_rs2data <= RS2data_i;
      r_imm     <= Imm_i;
      r_funct   <= Funct_i;
      r_rs1addr <= RS1addr_i;
      r_rs2addr <= RS2addr_i;
      r_rdaddr  <= RDaddr_i;
      if (w_haz && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  assign RegWrite_o  = r_ctrl.regwrite;
  assign MemtoReg_o  = r_ctrl.memtoreg;
  assign MemRead_o   = r_ctrl.memread;
  assign MemWrite_o  = r_ctrl.memwrite;
  assign ALUSrc_o    = r_ctrl.alusrc;
  assign ALUOp_o     = r_ctrl.aluop;
  assign RS1data_o   = r_rs1data;
  assign RS2data_o   = r_rs2data;
  assign Imm_o       = r_imm;
  assign Funct_o     = r_funct;
  assign RS1addr_o   = r_rs1addr;
  assign RS2addr_o   = r_rs2addr;
  assign RDaddr_o    = r_rdaddr;
  assign NoOp_o      = w_haz;
  assign Stall_o     = w_haz;
  assign PCWrite_o   = !w_haz;
  assign BubbleCnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage. A second instance with a
// 2-bit bubble counter shares the stimulus but has its own reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_b = 1'b0;
  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
  logic [1:0]  ALUOp_i;
  logic [31:0] RS1data_i, RS2data_i, Imm_i;
  logic [9:0]  Funct_i;
  logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;

  logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o;
  logic [1:0]  ALUOp_o;
  logic [31:0] RS1data_o, RS2data_o, Imm_o;
  logic [9:0]  Funct_o;
  logic [4:0]  RS1addr_o, RS2addr_o, RDaddr_o;
  logic        NoOp_o, Stall_o, PCWrite_o;
  logic [15:0] BubbleCnt_o;

  logic        b_RegWrite, b_MemtoReg, b_MemRead, b_MemWrite, b_ALUSrc;
  logic [1:0]  b_ALUOp;
  logic [31:0] b_RS1data, b_RS2data, b_Imm;
  logic [9:0]  b_Funct;
  logic [4:0]  b_RS1addr, b_RS2addr, b_RDaddr;
  logic        b_NoOp, b_Stall, b_PCWrite;
  logic [1:0]  b_BubbleCnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .Funct_i(Funct_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o),
    .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o), .Funct_o(Funct_o),
    .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
    .NoOp_o(NoOp_o), .Stall_o(Stall_o), .PCWrite_o(PCWrite_o),
    .BubbleCnt_o(BubbleCnt_o)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst_b),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .Funct_i(Funct_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .RegWrite_o(b_RegWrite), .MemtoReg_o(b_MemtoReg), .MemRead_o(b_MemRead),
    .MemWrite_o(b_MemWrite), .ALUSrc_o(b_ALUSrc), .ALUOp_o(b_ALUOp),
    .RS1data_o(b_RS1data), .RS2data_o(b_RS2data), .Imm_o(b_Imm), .Funct_o(b_Funct),
    .RS1addr_o(b_RS1addr), .RS2addr_o(b_RS2addr), .RDaddr_o(b_RDaddr),
    .NoOp_o(b_NoOp), .Stall_o(b_Stall), .PCWrite_o(b_PCWrite),
    .BubbleCnt_o(b_BubbleCnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    RegWrite_i = 0; MemtoReg_i = 0; MemRead_i = 0; MemWrite_i = 0; ALUSrc_i = 0;
    ALUOp_i = 2'd0; RS1data_i = '0; RS2data_i = '0; Imm_i = '0; Funct_i = '0;
    RS1addr_i = 0; RS2addr_i = 0; RDaddr_i = 0;
  endtask

  // lw rd, imm(rs1)
  task automatic drive_lw(input logic [4:0] rd, input logic [4:0] rs1);
    drive_idle();
    RegWrite_i = 1; MemtoReg_i = 1; MemRead_i = 1; ALUSrc_i = 1;
    ALUOp_i = 2'b00; RS1addr_i = rs1; RDaddr_i = rd; Imm_i = 32'd0;
  endtask

  // add rd, rs1, rs2
  task automatic drive_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    drive_idle();
    RegWrite_i = 1; ALUOp_i = 2'b10; RS1addr_i = rs1; RS2addr_i = rs2; RDaddr_i = rd;
  endtask

  initial begin
    drive_idle();
    rst = 0; rst_b = 0;
    step();
    step();

    // Reset state
    check_eq("rst_regwrite", RegWrite_o, 0);
    check_eq("rst_memread", MemRead_o, 0);
    check_eq("rst_rd", RDaddr_o, 0);
    check_eq("rst_cnt", BubbleCnt_o, 0);
    check_eq("rst_stall", Stall_o, 0);
    check_eq("rst_noop", NoOp_o, 0);
    check_eq("rst_pcwrite", PCWrite_o, 1);
    rst = 1; rst_b = 1;

    // Load-use on rs1
    drive_lw(5'd5, 5'd1);
    step();
    check_eq("lw_memread", MemRead_o, 1);
    check_eq("lw_rd", RDaddr_o, 5);
    drive_add(5'd7, 5'd5, 5'd2);
    #1;
    check_eq("lu_noop", NoOp_o, 1);
    check_eq("lu_stall", Stall_o, 1);
    check_eq("lu_pcwrite", PCWrite_o, 0);
    step();
    check_eq("bub_regwrite", RegWrite_o, 0);
    check_eq("bub_memread", MemRead_o, 0);
    check_eq("bub_memtoreg", MemtoReg_o, 0);
    check_eq("bub_alusrc", ALUSrc_o, 0);
    check_eq("bub_aluop", ALUOp_o, 0);
    check_eq("bub_rd_captured", RDaddr_o, 7);
    check_eq("bub_cnt", BubbleCnt_o, 1);
    check_eq("bub_noop", NoOp_o, 0);
    check_eq("bub_pcwrite", PCWrite_o, 1);
    step();
    check_eq("add_regwrite", RegWrite_o, 1);
    check_eq("add_aluop", ALUOp_o, 2);
    check_eq("add_rd", RDaddr_o, 7);
    check_eq("add_cnt", BubbleCnt_o, 1);

    // Load to x0 never stalls
    drive_lw(5'd0, 5'd1);
    step();
    drive_add(5'd9, 5'd0, 5'd0);
    #1;
    check_eq("x0_stall", Stall_o, 0);
    // Non-dependent load, then rs2 dependency
    drive_lw(5'd5, 5'd1);
    step();
    drive_add(5'd9, 5'd6, 5'd7);
    #1;
    check_eq("nodep_stall", Stall_o, 0);
    check_eq("nodep_pcwrite", PCWrite_o, 1);
    drive_add(5'd9, 5'd6, 5'd5);
    #1;
    check_eq("rs2_stall", Stall_o, 1);
    drive_add(5'd9, 5'd6, 5'd7);
    step();
    check_eq("nodep_cnt", BubbleCnt_o, 1);
    check_eq("nodep_regwrite", RegWrite_o, 1);

    // Chained loads: lw x5 ; lw x6,0(x5)
    drive_lw(5'd5, 5'd1);
    step();
    drive_lw(5'd6, 5'd5);
    #1;
    check_eq("chain_stall", Stall_o, 1);
    step();
    check_eq("chain_bub_memread", MemRead_o, 0);
    check_eq("chain_bub_cnt", BubbleCnt_o, 2);
    check_eq("chain_bub_stall", Stall_o, 0);
    step();
    check_eq("chain_memread", MemRead_o, 1);
    check_eq("chain_rd", RDaddr_o, 6);
    check_eq("chain_cnt", BubbleCnt_o, 2);

    // Pass-through of an R-type (EX holds lw x6, sources 3/4 independent)
    drive_add(5'd8, 5'd3, 5'd4);
    RS1data_i = 32'hDEADBEEF; RS2data_i = 32'h12345678;
    Imm_i = 32'hFFFF_F00D; Funct_i = 10'h2A5; MemWrite_i = 1;
    #1;
    check_eq("pt_stall", Stall_o, 0);
    step();
    check_eq("pt_regwrite", RegWrite_o, 1);
    check_eq("pt_aluop", ALUOp_o, 2);
    check_eq("pt_memread", MemRead_o, 0);
    check_eq("pt_memwrite", MemWrite_o, 1);
    check_eq("pt_rs1data", RS1data_o, 32'hDEADBEEF);
    check_eq("pt_rs2data", RS2data_o, 32'h12345678);
    check_eq("pt_imm", Imm_o, 32'hFFFF_F00D);
    check_eq("pt_funct", Funct_o, 10'h2A5);
    check_eq("pt_rs1addr", RS1addr_o, 3);
    check_eq("pt_rs2addr", RS2addr_o, 4);
    check_eq("pt_rd", RDaddr_o, 8);

    // Reset during a hazard
    drive_lw(5'd5, 5'd1);
    step();
    drive_add(5'd7, 5'd5, 5'd2);
    RS1data_i = 32'h1111_2222;
    #1;
    check_eq("rh_stall_pre", Stall_o, 1);
    rst = 0;
    step();
    check_eq("rh_regwrite", RegWrite_o, 0);
    check_eq("rh_memread", MemRead_o, 0);
    check_eq("rh_rs1data", RS1data_o, 0);
    check_eq("rh_rd", RDaddr_o, 0);
    check_eq("rh_cnt", BubbleCnt_o, 0);
    check_eq("rh_pcwrite", PCWrite_o, 1);
    check_eq("rh_noop", NoOp_o, 0);
    rst = 1;

    // Counter saturation on the CNT_W=2 instance
    drive_idle();
    rst_b = 0;
    step();
    check_eq("sat_rst_cnt", b_BubbleCnt, 0);
    rst_b = 1;
    for (int i = 0; i < 5; i++) begin
      drive_lw(5'd5, 5'd1);
      step();
      drive_add(5'd7, 5'd5, 5'd2);
      #1;
      check_eq($sformatf("sat_haz%0d", i), b_Stall, 1);
      step();
      check_eq($sformatf("sat_cnt%0d", i), b_BubbleCnt, (i < 3) ? (i + 1) : 3);
    end
    check_eq("main_cnt_after_sat", BubbleCnt_o, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
